player_motion: RTL and testbench

- Per-frame vertical physics for the surfer sprite; replaces the ad-hoc button-to-p_vpos logic in the top level.
- Consumes debounced up/down buttons, the wave surface height under the player, and the XVGA vsync; produces p_vpos for the display stage.
- Two-state rider: RIDE (glued to the wave surface) and AIR (ballistic, with gravity).

---
 rtl/player_motion.sv | 212 +++++++++++++++++++++
 tb/tb_player_motion.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/player_motion.sv
// player_motion
//   Per-frame vertical physics for the surfer sprite. The rider is either
//   glued to the wave surface (RIDE) or flying ballistically under gravity
//   (AIR). All state advances once per frame, on the rising edge of vsync.
//
//   Ports
//     clock        65 MHz pixel clock
//     reset_n      synchronous active-low reset
//     vsync        active-high vsync; rising edge marks a frame
//     up, down     debounced buttons (level); rising edges are latched
//     wave_height  wave surface row under the player, stable around vsync
//     p_vpos       player row, 0 at the top, clamped to 0..SCREEN_HEIGHT-1
//     velocity     signed rows/frame, positive is downward
//     airborne     1 while in AIR (registered)
//     frame_tick   one-cycle pulse when new p_vpos/velocity first appear
//
//   Optional feature macro: PLAYER_DOUBLE_JUMP_EN
//     When defined, one extra jump is allowed per airborne period.
module player_motion #(
    parameter int SCREEN_HEIGHT = 768,
    parameter int VPOS_INIT     = 384,
    parameter int JUMP_VEL      = 12,
    parameter int GRAVITY       = 1,
    parameter int MAX_FALL      = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              vsync,
    input  logic              up,
    input  logic              down,
    input  logic [9:0]        wave_height,
    output logic [9:0]        p_vpos,
    output logic signed [7:0] velocity,
    output logic              airborne,
    output logic              frame_tick
);

    typedef enum logic {
        RIDE = 1'b0,
        AIR  = 1'b1
    } state_t;

    // Position math runs in 12-bit signed so that overshoot past either
    // screen edge is visible before clamping back to 10 bits.
    localparam logic signed [11:0] POS_MAX   = 12'(SCREEN_HEIGHT - 1);
    localparam logic signed [11:0] JUMP_STEP = 12'(JUMP_VEL);
    localparam logic signed [11:0] FALL_STEP = 12'(MAX_FALL);
    localparam logic signed [11:0] GRAV_STEP = 12'(GRAVITY);
    localparam logic signed [7:0]  VEL_JUMP  = 8'(-JUMP_VEL);
    localparam logic signed [7:0]  VEL_MAX   = 8'(MAX_FALL);
    localparam logic [9:0]         POS_INIT  = 10'(VPOS_INIT);
    localparam logic [9:0]         POS_TOP   = POS_MAX[9:0];

    // Edge-detect delay registers
    logic vs_q, up_q, dn_q;
    // Latched button presses waiting for the next frame
    logic up_pend_q, up_pend_d;
    logic dn_pend_q, dn_pend_d;

    state_t            state_q, state_d;
    logic [9:0]        pos_q, pos_d;
    logic signed [7:0] vel_q, vel_d;
    logic              air_q, air_d;
    logic              tick_q, tick_d;
`ifdef PLAYER_DOUBLE_JUMP_EN
    logic              dj_used_q, dj_used_d;
`endif

    logic tick, up_rise, dn_rise, up_req, dn_req;
    logic signed [11:0] pos_ext, vel_ext, wave_ext;
    logic signed [11:0] next_pos, vel_new, vel_sum, rise_pos;

    function automatic logic [9:0] clamp_pos(input logic signed [11:0] p);
        logic [9:0] r;
        if (p < 12'sd0)
            r = 10'd0;
        else if (p > POS_MAX)
            r = POS_TOP;
        else
            r = p[9:0];
        return r;
    endfunction

    always_comb begin
        tick    = vsync & ~vs_q;
        up_rise = up & ~up_q;
        dn_rise = down & ~dn_q;

        // A press arriving in the tick cycle itself is seen by that tick.
        up_req  = up_pend_q | up_rise;
        dn_req  = dn_pend_q | dn_rise;

        up_pend_d = tick ? 1'b0 : up_req;
        dn_pend_d = tick ? 1'b0 : dn_req;

        pos_ext  = {2'b00, pos_q};
        vel_ext  = {{4{vel_q[7]}}, vel_q};
        wave_ext = {2'b00, wave_height};

        vel_sum  = vel_ext + GRAV_STEP;
        next_pos = pos_ext;
        vel_new  = vel_ext;
        rise_pos = wave_ext - JUMP_STEP;

        state_d = state_q;
        pos_d   = pos_q;
        vel_d   = vel_q;
        tick_d  = tick;
`ifdef PLAYER_DOUBLE_JUMP_EN
        dj_used_d = dj_used_q;
`endif

        if (tick) begin
            case (state_q)
                RIDE: begin
                    // Pending dive is meaningless on the surface; dropped.
                    if (up_req) begin
                        state_d = AIR;
                        vel_d   = VEL_JUMP;
                        pos_d   = clamp_pos(rise_pos);
                    end else begin
                        vel_d = 8'sd0;
                        pos_d = clamp_pos(wave_ext);
                    end
                end
                AIR: begin
                    if (dn_req) begin
                        vel_new  = FALL_STEP;
                        next_pos = pos_ext + FALL_STEP;
                    end
`ifdef PLAYER_DOUBLE_JUMP_EN
                    else if (up_req && !dj_used_q) begin
                        vel_new   = -JUMP_STEP;
                        next_pos  = pos_ext - JUMP_STEP;
                        dj_used_d = 1'b1;
                    end
`endif
                    else begin
                        // Position advances by the velocity held before this
                        // frame's gravity; velocity saturates at MAX_FALL.
                        next_pos = pos_ext + vel_ext;
                        vel_new  = (vel_sum > FALL_STEP) ? FALL_STEP : vel_sum;
                    end

                    if (next_pos < 12'sd0) begin
                        // Bump the ceiling: stop dead, keep flying.
                        pos_d = 10'd0;
                        vel_d = 8'sd0;
                    end else if (next_pos >= wave_ext && !vel_new[11]) begin
                        state_d = RIDE;
                        pos_d   = clamp_pos(wave_ext);
                        vel_d   = 8'sd0;
                    end else if (next_pos > POS_MAX) begin
                        state_d = RIDE;
                        pos_d   = POS_TOP;
                        vel_d   = 8'sd0;
                    end else begin
                        pos_d = next_pos[9:0];
                        vel_d = (vel_new > FALL_STEP) ? VEL_MAX : vel_new[7:0];
                    end
                end
                default: state_d = RIDE;
            endcase
        end

`ifdef PLAYER_DOUBLE_JUMP_EN
        // The extra jump is re-armed whenever the rider is on the surface.
        if (state_d == RIDE)
            dj_used_d = 1'b0;
`endif

        air_d = (state_d == AIR);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            vs_q      <= 1'b0;
            up_q      <= 1'b0;
            dn_q      <= 1'b0;
            up_pend_q <= 1'b0;
            dn_pend_q <= 1'b0;
            state_q   <= RIDE;
            pos_q     <= POS_INIT;
            vel_q     <= 8'sd0;
            air_q     <= 1'b0;
            tick_q    <= 1'b0;
`ifdef PLAYER_DOUBLE_JUMP_EN
            dj_used_q <= 1'b0;
`endif
        end else begin
            vs_q      <= vsync;
            up_q      <= up;
            dn_q      <= down;
            up_pend_q <= up_pend_d;
            dn_pend_q <= dn_pend_d;
            state_q   <= state_d;
            pos_q     <= pos_d;
            vel_q     <= vel_d;
            air_q     <= air_d;
            tick_q    <= tick_d;
`ifdef PLAYER_DOUBLE_JUMP_EN
            dj_used_q <= dj_used_d;
`endif
        end
    end

    assign p_vpos     = pos_q;
    assign velocity   = vel_q;
    assign airborne   = air_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_player_motion.sv
// Self-checking bench for player_motion: a constant vector table, a few
// hand-written multi-cycle sequences, then randomized frames compared
// against an integer reference model of the rider physics.
module tb_player_motion;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              vsync = 1'b0;
    logic              up = 1'b0;
    logic              down = 1'b0;
    logic [9:0]        wave_height = 10'd500;
    logic [9:0]        p_vpos;
    logic signed [7:0] velocity;
    logic              airborne;
    logic              frame_tick;

    player_motion dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .vsync      (vsync),
        .up         (up),
        .down       (down),
        .wave_height(wave_height),
        .p_vpos     (p_vpos),
        .velocity   (velocity),
        .airborne   (airborne),
        .frame_tick (frame_tick)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int m_pos = 384;
    int m_vel = 0;
    bit m_air = 1'b0;
    bit m_dj  = 1'b0;
    bit p_up  = 1'b0;
    bit p_dn  = 1'b0;

    typedef struct {
        bit u;
        bit d;
        int wave;
        int pos;
        int vel;
        bit air;
    } vec_t;

    vec_t vecs[26];

    function automatic int clampi(input int v);
        return (v < 0) ? 0 : ((v > 767) ? 767 : v);
    endfunction

    // One frame of rider physics, applied to the model.
    function automatic void model_frame(input int wave);
        int np, nv;
        if (!m_air) begin
            if (p_up) begin
                m_air = 1'b1;
                m_vel = -12;
                m_pos = clampi(wave - 12);
            end else begin
                m_pos = clampi(wave);
                m_vel = 0;
            end
        end else begin
            if (p_dn) begin
                nv = 16;
                np = m_pos + 16;
            end
`ifdef PLAYER_DOUBLE_JUMP_EN
            else if (p_up && !m_dj) begin
                nv = -12;
                np = m_pos - 12;
                m_dj = 1'b1;
            end
`endif
            else begin
                np = m_pos + m_vel;
                nv = (m_vel + 1 > 16) ? 16 : m_vel + 1;
            end
            if (np < 0) begin
                m_pos = 0;
                m_vel = 0;
            end else if (np >= wave && nv >= 0) begin
                m_pos = clampi(wave);
                m_vel = 0;
                m_air = 1'b0;
            end else if (np > 767) begin
                m_pos = 767;
                m_vel = 0;
                m_air = 1'b0;
            end else begin
                m_pos = np;
                m_vel = nv;
            end
            if (!m_air)
                m_dj = 1'b0;
        end
        p_up = 1'b0;
        p_dn = 1'b0;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, " p_vpos"}, int'(p_vpos), m_pos);
        chk({tag, " velocity"}, int'(velocity), m_vel);
        chk({tag, " airborne"}, int'(airborne), int'(m_air));
    endtask

    task automatic press(input bit u, input bit d);
        @(negedge clock);
        up   = u;
        down = d;
        p_up = p_up | u;
        p_dn = p_dn | d;
        @(negedge clock);
        up   = 1'b0;
        down = 1'b0;
    endtask

    // Raise vsync (optionally with up rising in the same cycle), wait for the
    // frame_tick pulse within a bounded window and advance the model.
    task automatic do_frame(input bit u_tick, input string tag);
        int n;
        @(negedge clock);
        vsync = 1'b1;
        if (u_tick) begin
            up   = 1'b1;
            p_up = 1'b1;
        end
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!frame_tick && n < 8);
        chk({tag, " frame_tick"}, int'(frame_tick), 1);
        model_frame(int'(wave_height));
        vsync = 1'b0;
        up    = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{0, 0, 500, 500,   0, 0};
        vecs[1]  = '{1, 0, 500, 488, -12, 1};
        vecs[2]  = '{0, 0, 500, 476, -11, 1};
        vecs[3]  = '{0, 0, 500, 465, -10, 1};
        vecs[4]  = '{0, 0, 500, 455,  -9, 1};
        vecs[5]  = '{0, 1, 500, 471,  16, 1};
        vecs[6]  = '{0, 0, 500, 487,  16, 1};
        vecs[7]  = '{0, 0, 500, 500,   0, 0};
        vecs[8]  = '{0, 0, 1000, 767,  0, 0};
        vecs[9]  = '{0, 0, 22,   22,   0, 0};
        vecs[10] = '{1, 0, 22,   10, -12, 1};
        vecs[11] = '{0, 0, 22,    0,   0, 1};
        vecs[12] = '{0, 0, 22,    0,   1, 1};
        vecs[13] = '{0, 0, 22,    1,   2, 1};
        vecs[14] = '{0, 1, 22,   17,  16, 1};
        vecs[15] = '{0, 0, 22,   22,   0, 0};
        vecs[16] = '{1, 0, 5,     0, -12, 1};
        vecs[17] = '{0, 0, 5,     0,   0, 1};
        vecs[18] = '{0, 1, 5,     5,   0, 0};
        vecs[19] = '{1, 0, 462, 450, -12, 1};
        vecs[20] = '{0, 1, 460, 460,   0, 0};
        vecs[21] = '{0, 0, 300, 300,   0, 0};
        vecs[22] = '{1, 1, 300, 288, -12, 1};
        vecs[23] = '{1, 1, 300, 300,   0, 0};
        vecs[24] = '{0, 1, 300, 300,   0, 0};
        vecs[25] = '{0, 0, 300, 300,   0, 0};

        // Reset state
        repeat (3) @(negedge clock);
        chk("reset p_vpos", int'(p_vpos), 384);
        chk("reset velocity", int'(velocity), 0);
        chk("reset airborne", int'(airborne), 0);
        chk("reset frame_tick", int'(frame_tick), 0);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        chk("idle p_vpos", int'(p_vpos), 384);

        // Table vectors
        for (int i = 0; i < 26; i++) begin
            wave_height = 10'(vecs[i].wave);
            if (vecs[i].u || vecs[i].d)
                press(vecs[i].u, vecs[i].d);
            do_frame(1'b0, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d p_vpos", i), int'(p_vpos), vecs[i].pos);
            chk($sformatf("vec%0d velocity", i), int'(velocity), vecs[i].vel);
            chk($sformatf("vec%0d airborne", i), int'(airborne), int'(vecs[i].air));
        end

        // Outputs hold between frames, and the pulse is one cycle wide
        repeat (5) @(negedge clock);
        chk("hold frame_tick", int'(frame_tick), 0);
        check_model("hold");

        // Up rising in the tick cycle is consumed by that tick
        wave_height = 10'd500;
        do_frame(1'b0, "pre_same");
        do_frame(1'b1, "same_cycle");
        chk("same_cycle p_vpos", int'(p_vpos), 488);
        chk("same_cycle velocity", int'(velocity), -12);
        chk("same_cycle airborne", int'(airborne), 1);

`ifdef PLAYER_DOUBLE_JUMP_EN
        // One mid-air jump allowed, the next one ignored
        press(1'b1, 1'b0);
        do_frame(1'b0, "dj1");
        chk("dj1 velocity", int'(velocity), -12);
        chk("dj1 p_vpos", int'(p_vpos), 476);
        press(1'b1, 1'b0);
        do_frame(1'b0, "dj2");
        chk("dj2 velocity", int'(velocity), -11);
        chk("dj2 p_vpos", int'(p_vpos), 464);
`endif

        // Reset mid-air overrides everything
        do_frame(1'b0, "air_step");
        chk("pre_reset airborne", int'(airborne), 1);
        @(negedge clock);
        reset_n = 1'b0;
        vsync   = 1'b1;
        @(negedge clock);
        chk("midair_reset p_vpos", int'(p_vpos), 384);
        chk("midair_reset velocity", int'(velocity), 0);
        chk("midair_reset airborne", int'(airborne), 0);
        chk("midair_reset frame_tick", int'(frame_tick), 0);
        reset_n = 1'b1;
        vsync   = 1'b0;
        m_pos = 384; m_vel = 0; m_air = 1'b0; m_dj = 1'b0;
        p_up = 1'b0; p_dn = 1'b0;
        @(negedge clock);

        // Randomized frames against the model
        for (int f = 0; f < 200; f++) begin
            wave_height = 10'($urandom_range(300, 700));
            if ($urandom_range(0, 3) == 0)
                press(1'b1, 1'b0);
            if ($urandom_range(0, 5) == 0)
                press(1'b0, 1'b1);
            if ($urandom_range(0, 7) == 0)
                press(1'b1, 1'b1);
            repeat ($urandom_range(0, 4)) @(negedge clock);
            do_frame($urandom_range(0, 15) == 0, $sformatf("rnd%0d", f));
            check_model($sformatf("rnd%0d", f));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
